// File: rtl/univ_mod_cntr.sv
// univ_mod_cntr: universal modulo counter.
//   Counts up or down by a programmable step within 0..mod_max (inclusive).
//   At a bound, it either wraps or saturates. A registered one-cycle pulse
//   and a sticky flag report each bound event.
//   Optional feature: macro UNIV_CNTR_SNAPSHOT_EN adds snap/snap_q. These
//   ports capture the pre-update count.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   syn_n_clr           synchronous clear, active-low (highest priority)
//   load, D             synchronous parallel load
//   en, up, step, sat   count enable, direction, step amount, saturate/wrap
//   mod_max             inclusive upper bound of the count range
//   clr_ovf             clears ovf_sticky (a same-edge event wins)
//   snap, snap_q        snapshot request / captured count (macro only)
//   Q                   current count
//   max_tick, min_tick  combinational Q == mod_max / Q == 0
//   wrap_pulse          high for the cycle after an event edge
//   ovf_sticky          sticky event flag
module univ_mod_cntr #(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              syn_n_clr,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [N-1:0]      D,
  input  logic [N-1:0]      mod_max,
  input  logic [STEP_W-1:0] step,
  input  logic              sat,
  input  logic              clr_ovf,
`ifdef UNIV_CNTR_SNAPSHOT_EN
  input  logic              snap,
  output logic [N-1:0]      snap_q,
`endif
  output logic [N-1:0]      Q,
  output logic              max_tick,
  output logic              min_tick,
  output logic              wrap_pulse,
  output logic              ovf_sticky
);

  logic [N-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         ovf_q, ovf_d;
  logic         evt;

  // Bound checks use N+1 bits, so Q+step can never alias back into range.
  logic [N:0]   q_ext, step_ext, mod_ext, sum;
  logic [N-1:0] diff;

  assign q_ext    = {1'b0, cnt_q};
  assign mod_ext  = {1'b0, mod_max};
  assign step_ext = {{(N+1-STEP_W){1'b0}}, step};
  assign sum      = q_ext + step_ext;
  assign diff     = cnt_q - step_ext[N-1:0];

  always_comb begin
    cnt_d = cnt_q;
    evt   = 1'b0;
    if (!syn_n_clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = D;
    end else if (en && (step != '0)) begin
      if (up) begin
        // A count that starts above mod_max always exceeds it, so it is an event.
        if (sum > mod_ext) begin
          evt   = 1'b1;
          cnt_d = sat ? mod_max : '0;
        end else begin
          cnt_d = sum[N-1:0];
        end
      end else begin
        if (step_ext > q_ext) begin
          evt   = 1'b1;
          cnt_d = sat ? '0 : mod_max;
        end else begin
          cnt_d = diff;
        end
      end
    end
  end

  always_comb begin
    wrap_d = evt;
    ovf_d  = ovf_q;
    if (evt) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef UNIV_CNTR_SNAPSHOT_EN
  logic [N-1:0] snap_reg_q;

  // The capture source is the pre-update count, independent of clear, load and enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_reg_q <= '0;
    end else if (snap) begin
      snap_reg_q <= cnt_q;
    end
  end

  assign snap_q = snap_reg_q;
`endif

  assign Q          = cnt_q;
  assign wrap_pulse = wrap_q;
  assign ovf_sticky = ovf_q;
  assign max_tick   = (cnt_q == mod_max);
  assign min_tick   = (cnt_q == '0);

endmodule
